// File: rtl/fft8_pkg.sv
// Shared constants, state encoding and index helpers for the 8-point FFT sequencer.
package fft8_pkg;

  localparam int PTS      = 8;
  localparam int LOG2_PTS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CALC   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  function automatic logic [LOG2_PTS-1:0] bitrev3(input logic [LOG2_PTS-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft8_seq_ctrl_if.sv
// Sample-in / result-out handshake bundle for the FFT sequencer.
interface fft8_seq_ctrl_if #(
  parameter int LOG2_PTS = 3
);
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [LOG2_PTS-1:0] rd_sel;

  modport master (
    output in_valid, out_ready,
    input  in_ready, out_valid, rd_sel
  );

  modport slave (
    input  in_valid, out_ready,
    output in_ready, out_valid, rd_sel
  );
endinterface

// File: rtl/fft8_cnt3.sv
// 3-bit up counter with synchronous clear (priority over enable) and terminal-count wrap flag.
module fft8_cnt3 (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] count,
  output logic       wrap
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en)
      count <= count + 3'd1;
  end

  assign wrap = en && (count == 3'd7);

endmodule

// File: rtl/fft8_seq_ctrl.sv
// Load / butterfly / unload sequencer for the 8-point FFT datapath.
// FFT8_SEQ_BITREV_LOAD_EN selects bit-reversed load order; otherwise reversal is applied on read.
module fft8_seq_ctrl #(
  parameter int PTS      = 8,
  parameter int LOG2_PTS = 3,
  parameter int STAGE_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  fft8_seq_ctrl_if.slave      bus,
  output logic [PTS-1:0]      ld_en,
  output logic [LOG2_PTS-1:0] ld_sel,
  output logic                stage_en,
  output logic [STAGE_W-1:0]  stage_sel,
  output logic                busy,
  output logic                done
);
  import fft8_pkg::*;

  state_t      state, state_n;
  logic [2:0]  cnt, stage;
  logic        cnt_wrap, stage_wrap;
  logic        in_xfer, out_xfer, stage_last;
  logic [LOG2_PTS-1:0] load_idx, read_idx;

  assign in_xfer    = bus.in_valid && ((state == IDLE) || (state == LOAD));
  assign out_xfer   = bus.out_ready && (state == UNLOAD);
  // stage_wrap can never fire while the stage count stops at 2; kept as a defensive exit
  assign stage_last = (state == CALC) && ((stage == 3'd2) || stage_wrap);

`ifdef FFT8_SEQ_BITREV_LOAD_EN
  assign load_idx = bitrev3(cnt);
  assign read_idx = cnt;
`else
  assign load_idx = cnt;
  assign read_idx = bitrev3(cnt);
`endif

  fft8_cnt3 u_sample_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (in_xfer || out_xfer),
    .count (cnt),
    .wrap  (cnt_wrap)
  );

  fft8_cnt3 u_stage_cnt (
    .clk   (clk),
    .clr   (rst || stage_last),
    .en    (state == CALC),
    .count (stage),
    .wrap  (stage_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (in_xfer)    state_n = LOAD;
      LOAD:   if (cnt_wrap)   state_n = CALC;
      CALC:   if (stage_last) state_n = UNLOAD;
      UNLOAD: if (cnt_wrap)   state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  // Strobes are gated by rst so nothing is written or reported in the reset cycle
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.rd_sel    = '0;
    ld_en         = '0;
    ld_sel        = '0;
    stage_en      = 1'b0;
    stage_sel     = '0;
    busy          = (state != IDLE);
    done          = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        bus.in_ready = 1'b1;
        if (in_xfer) begin
          ld_sel = load_idx;
          if (!rst)
            ld_en = PTS'(1) << load_idx;
        end
      end
      CALC: begin
        stage_en  = !rst;
        stage_sel = stage[STAGE_W-1:0];
      end
      UNLOAD: begin
        bus.out_valid = 1'b1;
        bus.rd_sel    = read_idx;
        done          = cnt_wrap && !rst;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Randomized scoreboard bench for fft8_seq_ctrl; honours FFT8_SEQ_BITREV_LOAD_EN like the RTL.
module tb_fft8_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ld_en;
  logic [2:0] ld_sel;
  logic       stage_en;
  logic [1:0] stage_sel;
  logic       busy;
  logic       done;

  fft8_seq_ctrl_if #(.LOG2_PTS(3)) bus ();

  fft8_seq_ctrl #(.PTS(8), .LOG2_PTS(3), .STAGE_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .stage_en  (stage_en),
    .stage_sel (stage_sel),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ldq[$];
  int rdq[$];

  function automatic int rev3(int v);
    return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sample i lands in register ldq[i]; the i-th result read must select rdq[i]
  // so that downstream sees natural frequency order.
  task automatic push_frame();
    for (int i = 0; i < 8; i++) begin
`ifdef FFT8_SEQ_BITREV_LOAD_EN
      ldq.push_back(rev3(i));
      rdq.push_back(i);
`else
      ldq.push_back(i);
      rdq.push_back(rev3(i));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: frame-level model (collect 8, three stage strobes, emit 8)
  int phase    = 0;
  int loads    = 0;
  int calc_k   = 0;
  int unloads  = 0;
  bit post_rst = 1'b0;

  always @(negedge clk) begin
    int exp;
    if (rst) begin
      chk("rst_ld_en", int'(ld_en), 0);
      chk("rst_stage_en", int'(stage_en), 0);
      chk("rst_done", int'(done), 0);
      ldq.delete();
      rdq.delete();
      phase = 0; loads = 0; calc_k = 0; unloads = 0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("idle_in_ready", int'(bus.in_ready), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_out_valid", int'(bus.out_valid), 0);
        post_rst = 1'b0;
      end
      case (phase)
        0: begin
          chk("load_in_ready", int'(bus.in_ready), 1);
          chk("load_stage_en", int'(stage_en), 0);
          chk("load_out_valid", int'(bus.out_valid), 0);
          chk("load_done", int'(done), 0);
          chk("load_busy", int'(busy), int'(loads != 0));
          if (bus.in_valid) begin
            if (ldq.size() == 0) begin
              checks++; errors++;
              $display("FAIL load_unexpected: got ld_en=%0d expected no pending sample at %0t", ld_en, $time);
            end else begin
              exp = ldq.pop_front();
              chk("ld_sel", int'(ld_sel), exp);
              chk("ld_en", int'(ld_en), 1 << exp);
              loads++;
              if (loads == 8) begin
                phase = 1; calc_k = 0;
              end
            end
          end else begin
            chk("ld_en_idle", int'(ld_en), 0);
          end
        end
        1: begin
          chk("calc_in_ready", int'(bus.in_ready), 0);
          chk("calc_ld_en", int'(ld_en), 0);
          chk("calc_stage_en", int'(stage_en), 1);
          chk("calc_stage_sel", int'(stage_sel), calc_k);
          chk("calc_out_valid", int'(bus.out_valid), 0);
          chk("calc_busy", int'(busy), 1);
          calc_k++;
          if (calc_k == 3) phase = 2;
        end
        default: begin
          chk("unload_out_valid", int'(bus.out_valid), 1);
          chk("unload_in_ready", int'(bus.in_ready), 0);
          chk("unload_stage_en", int'(stage_en), 0);
          chk("unload_busy", int'(busy), 1);
          if (rdq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unload_unexpected: got rd_sel=%0d expected no pending result at %0t", bus.rd_sel, $time);
          end else begin
            chk("rd_sel", int'(bus.rd_sel), rdq[0]);
            if (bus.out_ready) begin
              void'(rdq.pop_front());
              unloads++;
              chk("done_pulse", int'(done), int'(unloads == 8));
              if (unloads == 8) begin
                phase = 0; loads = 0; unloads = 0;
              end
            end else begin
              chk("done_stall", int'(done), 0);
            end
          end
        end
      endcase
    end
  end

  // vmode/rmode: 0 = always high, 1 = patterned, 2 = random
  task automatic run_frame(int vmode, int rmode);
    bit got_done = 1'b0;
    int first    = -1;
    push_frame();
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      step();
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (cyc % 2) == 0;
        default: bus.in_valid = $urandom_range(0, 1) == 1;
      endcase
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3) == 0;
        default: bus.out_ready = $urandom_range(0, 3) != 0;
      endcase
      #1;
      if (first < 0 && bus.in_valid && bus.in_ready) first = cyc;
      if (done) begin
        got_done = 1'b1;
        if (vmode == 0 && rmode == 0)
          chk("frame_cycles", cyc - first + 1, 19);
      end
    end
    chk("frame_done_seen", int'(got_done), 1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic abort_load();
    int n = 0;
    push_frame();
    for (int cyc = 0; cyc < 50 && n < 4; cyc++) begin
      step();
      bus.in_valid = 1'b1;
      #1;
      if (bus.in_ready) n++;
    end
    chk("abort_load_progress", n, 4);
    step();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic abort_stage();
    bit found = 1'b0;
    push_frame();
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      step();
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      if (stage_en && stage_sel == 2'd1) begin
        rst = 1'b1;
        found = 1'b1;
      end
    end
    chk("abort_stage_reached", int'(found), 1);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    run_frame(0, 1);
    run_frame(1, 0);
    abort_load();
    run_frame(0, 0);
    abort_stage();
    run_frame(2, 2);
    for (int f = 0; f < 6; f++)
      run_frame(2, 2);
    run_frame(0, 0);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
